pipe_hazard_ctrl: RTL

//  Hazard/stall/flush controller for the 5-stage MIPS pipeline (F/D/E/M/W). Successor of the

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/div_seq.sv | 77 +++++++
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and types for the pipeline hazard
//                controller: forwarding mux encodings, divider sequencer
//                state encoding, default GPR index width and a small helper
//                that resolves M-over-W forwarding priority.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int RA_W = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        DIV = 1'b1
    } div_state_t;

    // The younger producer (M) always holds the newest value, so it wins.
    function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
        if (m_hit)
            return FWD_M;
        else if (w_hit)
            return FWD_W;
        else
            return FWD_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Multi-cycle divide sequencer. Holds the front of the pipe
//                for exactly DIV_CYCLES cycles per divide (longer only when
//                frozen by a data-SRAM wait). An exception cancels at once.
//  Ports       : clk, resetn (async, active low)
//                start  - E stage holds div/divu
//                freeze - memory wait; counter holds its value
//                cancel - exception in M; abort any divide in flight
//                busy   - sequencer is in its DIV state
//                stall  - divide stall request (launch cycle included)
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq
    import cpu_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic freeze,
    input  logic cancel,
    output logic busy,
    output logic stall
);

    localparam int              CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_launch;

    // The launch cycle itself counts as the first stall cycle, so the counter
    // is loaded with DIV_CYCLES-1 and the last DIV cycle is the one with cnt==1.
    assign w_launch = (r_state == RUN) && start && !freeze && !cancel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_launch) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= DIV;
                    end
                end
                DIV: begin
                    if (cancel) begin
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else if (!freeze) begin
                        if (r_cnt <= CNT_W'(1)) begin
                            r_cnt   <= '0;
                            r_state <= RUN;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign busy  = (r_state == DIV);
    assign stall = w_launch | busy;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Hazard, stall, flush and forwarding control for the 5-stage
//                F/D/E/M/W pipeline. Resolves GPR and HI/LO forwarding,
//                load-use and branch/jump operand stalls, divide sequencing,
//                data-SRAM waits and precise exception flush.
//  Ports       : clk, resetn (async, active low)
//                D/E/M/W register ids, write enables, load/hilo/div/mem/exc
//                qualifiers in; forwarding selects, per-stage stall/flush,
//                div_busy, div_cancel, exc_redirect out.
//                Priority: excM > mem wait > divide > data hazard.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int RA_W       = cpu_pkg::RA_W,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [RA_W-1:0] rsD,
    input  logic [RA_W-1:0] rtD,
    input  logic            rs_useD,
    input  logic            rt_useD,
    input  logic            branchD,
    input  logic            jumpD,
    input  logic [RA_W-1:0] rsE,
    input  logic [RA_W-1:0] rtE,
    input  logic [RA_W-1:0] write_regE,
    input  logic [RA_W-1:0] write_regM,
    input  logic [RA_W-1:0] write_regW,
    input  logic            reg_write_enE,
    input  logic            reg_write_enM,
    input  logic            reg_write_enW,
    input  logic            mem_to_regE,
    input  logic            mem_to_regM,
    input  logic            hilo_readE,
    input  logic            hilo_write_enM,
    input  logic            hilo_write_enW,
    input  logic            div_startE,
    input  logic            mem_reqM,
    input  logic            mem_data_okM,
    input  logic            excM,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            forwardAD,
    output logic            forwardBD,
    output logic [1:0]      forward_hiloE,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            stallM,
    output logic            stallW,
    output logic            flushD,
    output logic            flushE,
    output logic            flushM,
    output logic            flushW,
    output logic            div_busy,
    output logic            div_cancel,
    output logic            exc_redirect
);

    import cpu_pkg::*;

    logic w_mstall, w_divstall, w_dstall;
    logic w_lwstall, w_brstall, w_jstall;
    logic w_rs_hitE, w_rt_hitE, w_rs_hitM, w_rt_hitM;
    logic w_seq_busy, w_seq_stall;

    // D-stage source compared against E/M destinations; $0 never hazards.
    assign w_rs_hitE = rs_useD && (write_regE != '0) && (rsD == write_regE);
    assign w_rt_hitE = rt_useD && (write_regE != '0) && (rtD == write_regE);
    assign w_rs_hitM = rs_useD && (write_regM != '0) && (rsD == write_regM);
    assign w_rt_hitM = rt_useD && (write_regM != '0) && (rtD == write_regM);

    assign w_lwstall = mem_to_regE && reg_write_enE && (w_rs_hitE || w_rt_hitE);
    assign w_brstall = branchD && ((reg_write_enE && (w_rs_hitE || w_rt_hitE)) ||
                                   (mem_to_regM && (w_rs_hitM || w_rt_hitM)));
    // jr/jalr read rs only, so an rt match must not hold the jump.
    assign w_jstall  = jumpD && ((reg_write_enE && (write_regE != '0) && (rsD == write_regE)) ||
                                 (mem_to_regM && (write_regM != '0) && (rsD == write_regM)));
    assign w_dstall  = w_lwstall | w_brstall | w_jstall;

    assign w_mstall  = mem_reqM && !mem_data_okM;

    div_seq #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk    (clk),
        .resetn (resetn),
        .start  (div_startE),
        .freeze (w_mstall),
        .cancel (excM),
        .busy   (w_seq_busy),
        .stall  (w_seq_stall)
    );

    assign w_divstall = w_seq_stall;

    always_comb begin
        forwardAE     = FWD_NONE;
        forwardBE     = FWD_NONE;
        forwardAD     = 1'b0;
        forwardBD     = 1'b0;
        forward_hiloE = FWD_NONE;
        stallF        = 1'b0;
        stallD        = 1'b0;
        stallE        = 1'b0;
        stallM        = 1'b0;
        stallW        = 1'b0;
        flushD        = 1'b0;
        flushE        = 1'b0;
        flushM        = 1'b0;
        flushW        = 1'b0;
        div_busy      = 1'b0;
        div_cancel    = 1'b0;
        exc_redirect  = 1'b0;
        if (resetn) begin
            forwardAE = fwd_sel((rsE != '0) && reg_write_enM && (rsE == write_regM),
                                (rsE != '0) && reg_write_enW && (rsE == write_regW));
            forwardBE = fwd_sel((rtE != '0) && reg_write_enM && (rtE == write_regM),
                                (rtE != '0) && reg_write_enW && (rtE == write_regW));
            forwardAD = (rsD != '0) && (rsD == write_regM) && reg_write_enM;
            forwardBD = (rtD != '0) && (rtD == write_regM) && reg_write_enM;
            forward_hiloE = fwd_sel(hilo_readE && hilo_write_enM,
                                    hilo_readE && hilo_write_enW);
            div_busy  = w_seq_busy;

            if (excM) begin
                flushD       = 1'b1;
                flushE       = 1'b1;
                flushM       = 1'b1;
                flushW       = 1'b1;
                exc_redirect = 1'b1;
                div_cancel   = w_seq_busy;
            end else if (w_mstall) begin
                // M waits on the SRAM; W gets a bubble so it does not retire twice.
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (w_divstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (w_dstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
